circ_mtx_row_sequencer: RTL and testbench

//  Time-multiplexes one shared dot-product engine across all rows of a circulant M31 matrix-vector product.

---
 rtl/circ_mtx_row_sequencer.sv | 121 ++++++++++++
 tb/tb_circ_mtx_row_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circ_mtx_row_sequencer.sv
// Row-serial circulant matrix-vector product over M31.
// Feeds one shared dot-product engine one rotated row at a time.
module circ_mtx_row_sequencer #(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  mtx_row,
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  vec,
  output logic                                 dp_start,
  output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  dp_row,
  output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  dp_vec,
  input  logic                                 dp_valid,
  input  logic [WORD_WIDTH-1:0]                dp_result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  result
);

  localparam int CW = $clog2(MTX_SIZE);

  typedef logic [CW-1:0] row_t;

  localparam row_t LAST_ROW = row_t'(MTX_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;
  row_t   row;

  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] lmtx;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] lvec;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] res;

  logic accept;
  logic capture;
  logic last;

  assign last = (row == LAST_ROW);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    in_ready  = 1'b0;
    dp_start  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = ~reset;
        if (in_valid && !reset) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // dp_valid here may be a stale level from the previous row
        dp_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dp_valid) begin
          capture   = 1'b1;
          state_nxt = last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      row   <= '0;
      lmtx  <= '0;
      lvec  <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lmtx <= mtx_row;
        lvec <= vec;
        row  <= '0;
      end
      if (capture) begin
        res[row] <= dp_result;
        if (!last) begin
          row <= row + row_t'(1);
        end
      end
    end
  end

  // Power-of-two size lets the index subtraction wrap for free
  for (genvar j = 0; j < MTX_SIZE; j++) begin : g_rot
    row_t idx;
    assign idx       = row_t'(j) - row;
    assign dp_row[j] = lmtx[idx];
  end

  assign dp_vec = lvec;
  assign result = res;

endmodule

// File: tb/tb_circ_mtx_row_sequencer.sv
// Directed bench for circ_mtx_row_sequencer with a
// behavioural M31 dot-product engine of configurable latency.
module tb_circ_mtx_row_sequencer;

  localparam int W = 31;
  localparam int N = 16;
  localparam logic [63:0] P = 64'h7FFF_FFFF;

  typedef logic [N-1:0][W-1:0] arr_t;

  typedef struct {
    string name;
    arr_t  mtx;
    arr_t  vec;
    arr_t  exp;
    int    k;
    bit    vark;
    bit    hold;
    int    lat;
    bit    r15;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  arr_t mtx_row;
  arr_t vec;
  logic dp_start;
  arr_t dp_row;
  arr_t dp_vec;
  logic dp_valid;
  logic [W-1:0] dp_result;
  logic out_valid;
  logic out_ready;
  arr_t result;

  circ_mtx_row_sequencer #(.WORD_WIDTH(W), .MTX_SIZE(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mtx_row   (mtx_row),
    .vec       (vec),
    .dp_start  (dp_start),
    .dp_row    (dp_row),
    .dp_vec    (dp_vec),
    .dp_valid  (dp_valid),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      passed++;
  endtask

  function automatic logic [W-1:0] dot(input arr_t r, input arr_t v);
    logic [63:0] acc;
    acc = 0;
    for (int j = 0; j < N; j++)
      acc = (acc + (64'(r[j]) * 64'(v[j])) % P) % P;
    return acc[W-1:0];
  endfunction

  // engine model configuration and observations
  int       eng_k    = 3;
  bit       eng_var  = 0;
  bit       eng_hold = 0;
  int       starts   = 0;
  int       cnt      = 0;
  logic [W-1:0] eng_res;
  logic [W-1:0] r15_d0;

  initial begin
    dp_valid  = 0;
    dp_result = 0;
    eng_res   = 0;
    r15_d0    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        dp_valid = 0;
        cnt = 0;
      end else if (dp_start) begin
        starts++;
        if (starts == N) r15_d0 = dp_row[0];
        eng_res = dot(dp_row, dp_vec);
        cnt = eng_var ? 1 + ((starts - 1) % 7) : eng_k;
        if (!eng_hold) dp_valid = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          dp_valid  = 1;
          dp_result = eng_res;
        end else begin
          dp_valid = 0;
        end
      end else if (!eng_hold) begin
        dp_valid = 0;
      end
    end
  end

  vec_t tv[4];

  task automatic start_req(input arr_t m, input arr_t v, output int a);
    @(negedge clk);
    mtx_row  = m;
    vec      = v;
    in_valid = 1;
    a = -1;
    for (int n = 0; n < 100; n++) begin
      if (in_ready) begin
        a = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("accept_seen", a >= 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int d);
    d = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (out_valid) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) $display("FAIL out_valid_timeout: got 0 expected 1");
  endtask

  task automatic run_vec(input int i);
    int a, d;
    bit busy_bad, stall_bad;
    arr_t snap, junk;
    eng_k    = tv[i].k;
    eng_var  = tv[i].vark;
    eng_hold = tv[i].hold;
    starts   = 0;
    start_req(tv[i].mtx, tv[i].vec, a);
    for (int j = 0; j < N; j++) junk[j] = W'(1000 + j);
    mtx_row  = junk;
    vec      = junk;
    in_valid = 1;
    busy_bad = 0;
    d = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (out_valid) begin
        d = cyc;
        break;
      end
      if (in_ready) busy_bad = 1;
    end
    in_valid = 0;
    chk({tv[i].name, "_latency"}, 64'(d - a), 64'(tv[i].lat));
    chk({tv[i].name, "_busy_ready"}, 64'(busy_bad), 0);
    chk({tv[i].name, "_starts"}, 64'(starts), 64'(N));
    for (int j = 0; j < N; j++)
      chk($sformatf("%s_result[%0d]", tv[i].name, j),
          64'(result[j]), 64'(tv[i].exp[j]));
    if (tv[i].r15)
      chk({tv[i].name, "_row15_dp_row0"}, 64'(r15_d0), 1);
    snap = result;
    stall_bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!out_valid || result !== snap) stall_bad = 1;
    end
    chk({tv[i].name, "_stall_stable"}, 64'(stall_bad), 0);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tv[i].name, "_idle_out_valid"}, 64'(out_valid), 0);
    chk({tv[i].name, "_idle_in_ready"}, 64'(in_ready), 1);
    chk({tv[i].name, "_result_persist"}, 64'(result === snap), 1);
  endtask

  initial begin
    int a, d, d1, a2;
    arr_t z, m, v;
    bit bad;

    z = '0;
    for (int i = 0; i < 4; i++) begin
      tv[i].mtx  = '0;
      tv[i].vec  = '0;
      tv[i].exp  = '0;
      tv[i].k    = 3;
      tv[i].vark = 0;
      tv[i].hold = 0;
      tv[i].lat  = 65;
      tv[i].r15  = 0;
    end
    tv[0].name = "identity";
    tv[0].mtx[0] = 1;
    for (int j = 0; j < N; j++) begin
      tv[0].vec[j] = W'(j);
      tv[0].exp[j] = W'(j);
    end
    tv[1].name = "rotation";
    tv[1].mtx[1] = 1;
    tv[1].r15 = 1;
    for (int j = 0; j < N; j++) begin
      tv[1].vec[j] = W'(j);
      tv[1].exp[j] = W'((j + 1) % N);
    end
    tv[2].name = "field";
    tv[2].k = 2;
    tv[2].lat = 49;
    for (int j = 0; j < N; j++) begin
      tv[2].mtx[j] = 31'h7FFF_FFFE;
      tv[2].vec[j] = 31'd1;
      tv[2].exp[j] = 31'h7FFF_FFEF;
    end
    tv[3].name = "vark_hold";
    tv[3].vark = 1;
    tv[3].hold = 1;
    tv[3].lat = 76;
    tv[3].mtx[2] = 1;
    for (int j = 0; j < N; j++) begin
      tv[3].vec[j] = W'(3 * j + 7);
      tv[3].exp[j] = W'(3 * ((j + 2) % N) + 7);
    end

    reset     = 1;
    in_valid  = 0;
    out_ready = 0;
    mtx_row   = '0;
    vec       = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_dp_start", 64'(dp_start), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_result", 64'(result === z), 1);
    reset = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 1);

    for (int i = 0; i < 4; i++) run_vec(i);

    // reset while waiting on row 5
    eng_k = 3;
    eng_var = 0;
    eng_hold = 0;
    starts = 0;
    start_req(tv[0].mtx, tv[0].vec, a);
    for (int n = 0; n < 200 && starts < 6; n++) @(negedge clk);
    @(negedge clk);
    chk("mid_starts", 64'(starts), 6);
    chk("mid_result4", 64'(result[4]), 4);
    reset = 1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_dp_start", 64'(dp_start), 0);
    chk("mid_rst_result", 64'(result === z), 1);
    chk("mid_rst_dp_row", 64'(dp_row === z), 1);
    chk("mid_rst_dp_vec", 64'(dp_vec === z), 1);
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (dp_start || out_valid || in_ready) bad = 1;
    end
    chk("mid_rst_quiet", 64'(bad), 0);
    reset = 0;
    @(negedge clk);
    chk("mid_rel_in_ready", 64'(in_ready), 1);
    chk("mid_rel_dp_start", 64'(dp_start), 0);

    // back-to-back with in_valid held high
    starts = 0;
    out_ready = 1;
    @(negedge clk);
    mtx_row = tv[0].mtx;
    vec = tv[0].vec;
    in_valid = 1;
    a = -1;
    for (int n = 0; n < 100; n++) begin
      if (in_ready) begin
        a = cyc;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mtx_row = tv[1].mtx;
    vec = tv[1].vec;
    wait_out(d1);
    chk("b2b_first_latency", 64'(d1 - a), 65);
    chk("b2b_done_in_ready", 64'(in_ready), 0);
    chk("b2b_first_result", 64'(result === tv[0].exp), 1);
    @(negedge clk);
    a2 = in_ready ? cyc : -1;
    chk("b2b_second_accept", 64'(a2 - d1), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    wait_out(d);
    chk("b2b_second_latency", 64'(d - a2), 65);
    chk("b2b_second_result", 64'(result === tv[1].exp), 1);
    chk("b2b_starts", 64'(starts), 32);
    out_ready = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
